// File: rtl/lfsr_prbs_checker_if.sv
// Handshake/result bundle between a PRBS bit source and the checker.
interface lfsr_prbs_checker_if #(
  parameter int unsigned CNT_W = 16
);
  logic             en;
  logic             din;
  logic             clear_cnt;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic [1:0]       state_o;

  // Source side: drives bits, observes checker status.
  modport master (
    output en, din, clear_cnt,
    input  locked, err, err_cnt, state_o
  );

  // Checker side.
  modport slave (
    input  en, din, clear_cnt,
    output locked, err, err_cnt, state_o
  );
endinterface

// File: rtl/lfsr_prbs_checker.sv
// Self-seeding Fibonacci LFSR PRBS checker: seeds from the stream, verifies,
// then flywheels on its own prediction and counts bit errors.
module lfsr_prbs_checker #(
  parameter int unsigned     WIDTH    = 4,
  parameter logic [WIDTH-1:0] TAPS    = 4'b1100,
  parameter int unsigned     LOCK_CNT = 8,
  parameter int unsigned     LOSS_CNT = 4,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  lfsr_prbs_checker_if.slave bus
);

  localparam logic [1:0] SEED   = 2'b00;
  localparam logic [1:0] VERIFY = 2'b01;
  localparam logic [1:0] LOCKED = 2'b10;
  localparam logic [1:0] LOST   = 2'b11;

  localparam int unsigned SEED_W  = $clog2(WIDTH + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W  = $clog2(LOSS_CNT + 1);

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] s_q,      s_d;
  logic [SEED_W-1:0]  seed_q,  seed_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MISS_W-1:0]  miss_q,  miss_d;
  logic             locked_q, locked_d;
  logic             err_q,    err_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  logic             pred;
  logic             mismatch;
  logic [WIDTH-1:0] s_din;

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    seed_d   = seed_q;
    match_d  = match_q;
    miss_d   = miss_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    locked_d = (state_q == LOCKED);
    pred     = ^(s_q & TAPS);
    mismatch = (bus.din != pred);
    s_din    = {s_q[WIDTH-2:0], bus.din};

    case (state_q)
      SEED: begin
        if (bus.en) begin
          s_d = s_din;
          if (seed_q == SEED_W'(WIDTH - 1)) begin
            // all-zero register is the LFSR lock-up state; seed again
            seed_d = '0;
            if (s_din != '0) state_d = VERIFY;
          end else begin
            seed_d = seed_q + SEED_W'(1);
          end
        end
      end
      VERIFY: begin
        if (bus.en) begin
          s_d = s_din;
          if (!mismatch) begin
            if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
              match_d = '0;
              state_d = LOCKED;
            end else begin
              match_d = match_q + MATCH_W'(1);
            end
          end else begin
            match_d = '0;
            seed_d  = '0;
            state_d = SEED;
          end
        end
      end
      LOCKED: begin
        if (bus.en) begin
          // flywheel: advance on the prediction so one bad bit is one error
          s_d = {s_q[WIDTH-2:0], pred};
          if (mismatch) begin
            err_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            if (miss_q == MISS_W'(LOSS_CNT - 1)) begin
              miss_d  = '0;
              state_d = LOST;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end else begin
            miss_d = '0;
          end
        end
      end
      LOST: begin
        seed_d  = '0;
        state_d = SEED;
      end
      default: state_d = SEED;
    endcase

    if (bus.clear_cnt) cnt_d = '0;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SEED;
      s_q      <= '0;
      seed_q   <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      seed_q   <= seed_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.locked  = locked_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = cnt_q;
  assign bus.state_o = state_q;

endmodule
